// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared op encodings, FSM states and constants for the RV32M divider
package div_unit_pkg;
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, FINAL, DONE} div_state_e;
  localparam int DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  function automatic logic [31:0] special_result(input logic is_rem, input logic dz, input logic [31:0] rs1);
    return dz ? (is_rem ? rs1 : ALL_ONES) : (is_rem ? 32'h0 : INT_MIN);
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request and writeback handshake bundle between the core and div_unit
interface div_unit_if;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1_rdata;
  logic [31:0] i_rs2_rdata;
  logic [4:0]  i_rd_waddr;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  modport slave (
    input  i_valid, i_op, i_rs1_rdata, i_rs2_rdata, i_rd_waddr, i_flush, i_ready,
    output o_ready, o_valid, o_rd_waddr, o_rd_wdata
  );
  modport master (
    output i_valid, i_op, i_rs1_rdata, i_rs2_rdata, i_rd_waddr, i_flush, i_ready,
    input  o_ready, o_valid, o_rd_waddr, o_rd_wdata
  );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring shift/subtract iteration of an unsigned radix-2 divide
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);
  logic [W:0] sh, diff;
  assign sh = {rem, quo[W-1]};
  // Top bit of the W+1-bit difference is the borrow: set means keep the shifted remainder
  assign diff = sh - {1'b0, dvs};
  assign rem_nxt = diff[W] ? sh[W-1:0] : diff[W-1:0];
  assign quo_nxt = {quo[W-2:0], ~diff[W]};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 RV32M DIV/DIVU/REM/REMU with valid/ready writeback.
// DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete one edge after accept.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic i_clk,
  input logic i_rst_n,
  div_unit_if.slave bus
);
  div_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, rem_nxt, quo_nxt, abs1, abs2, q_fix, r_fix, wdata_q;
  logic [4:0] rd_q, waddr_q;
  logic is_rem, neg_q, neg_r, dz, sgn, s1, s2, accept, fast_sp;
  assign accept = bus.i_valid && bus.o_ready && !bus.i_flush;
  assign sgn = ~bus.i_op[0];
  assign s1 = sgn & bus.i_rs1_rdata[WIDTH-1];
  assign s2 = sgn & bus.i_rs2_rdata[WIDTH-1];
  assign abs1 = s1 ? -bus.i_rs1_rdata : bus.i_rs1_rdata;
  assign abs2 = s2 ? -bus.i_rs2_rdata : bus.i_rs2_rdata;
`ifdef DIV_FAST_SPECIAL_EN
  assign fast_sp = bus.i_rs2_rdata == '0 ||
                   (sgn && bus.i_rs1_rdata == INT_MIN && bus.i_rs2_rdata == ALL_ONES);
`else
  assign fast_sp = 1'b0;
`endif
  div_step #(.W(WIDTH)) u_step (
    .rem(rem), .quo(quo), .dvs(dvs), .rem_nxt(rem_nxt), .quo_nxt(quo_nxt)
  );
  // Overflow falls out of the unsigned path; only the zero-divisor quotient needs forcing
  assign q_fix = dz ? ALL_ONES : (neg_q ? -quo : quo);
  assign r_fix = neg_r ? -rem : rem;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = bus.i_flush ? IDLE :
                state == IDLE  ? (accept ? (fast_sp ? DONE : BUSY) : IDLE) :
                state == BUSY  ? (cnt == CNT_W'(DIV_ITERS - 1) ? FINAL : BUSY) :
                state == FINAL ? DONE :
                bus.i_ready    ? IDLE : DONE;
  end
  always_comb begin
    bus.o_ready = state == IDLE;
    bus.o_valid = state == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      rd_q    <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else if (bus.i_flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= abs1;
      dvs    <= abs2;
      rd_q   <= bus.i_rd_waddr;
      is_rem <= bus.i_op[1];
      neg_q  <= s1 ^ s2;
      neg_r  <= s1;
      dz     <= bus.i_rs2_rdata == '0;
      if (fast_sp) begin
        wdata_q <= special_result(bus.i_op[1], bus.i_rs2_rdata == '0, bus.i_rs1_rdata);
        waddr_q <= bus.i_rd_waddr;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      rem <= rem_nxt;
      quo <= quo_nxt;
    end else if (state == FINAL) begin
      cnt     <= '0;
      wdata_q <= is_rem ? r_fix : q_fix;
      waddr_q <= rd_q;
    end
  assign bus.o_rd_wdata = wdata_q;
  assign bus.o_rd_waddr = waddr_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 34;
`endif
  logic clk, rst_n;
  int vectors, miscompares;
  div_unit_if bus();
  div_unit dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.i_op = op;
    bus.i_rs1_rdata = a;
    bus.i_rs2_rdata = b;
    bus.i_rd_waddr = rd;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b, rd);
    check({tag, " busy_ready"}, {31'd0, bus.o_ready}, 32'd0);
    wait_valid(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " wdata"}, bus.o_rd_wdata, exp);
    check({tag, " waddr"}, {27'd0, bus.o_rd_waddr}, {27'd0, rd});
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_ready = 1'b0;
    check({tag, " ready_after"}, {31'd0, bus.o_ready}, 32'd1);
    check({tag, " valid_after"}, {31'd0, bus.o_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_op = 2'b00;
    bus.i_rs1_rdata = '0;
    bus.i_rs2_rdata = '0;
    bus.i_rd_waddr = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    #22;
    check("rst valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst wdata", bus.o_rd_wdata, 32'd0);
    check("rst waddr", {27'd0, bus.o_rd_waddr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst ready", {31'd0, bus.o_ready}, 32'd1);

    run("divu", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run("remu", 2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 34);
    run("div_neg", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2, 34);
    run("rem_neg", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd8, 32'hFFFF_FFFE, 34);
    run("rem_negdiv", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd9, 32'd2, 34);
    run("div_dz", 2'b00, 32'h1234_5678, 32'd0, 5'd10, 32'hFFFF_FFFF, SP_LAT);
    run("divu_dz", 2'b01, 32'h1234_5678, 32'd0, 5'd11, 32'hFFFF_FFFF, SP_LAT);
    run("rem_dz", 2'b10, 32'h1234_5678, 32'd0, 5'd12, 32'h1234_5678, SP_LAT);
    run("remu_dz", 2'b11, 32'h1234_5678, 32'd0, 5'd13, 32'h1234_5678, SP_LAT);
    run("div_neg_dz", 2'b00, 32'hFFFF_FF9C, 32'd0, 5'd14, 32'hFFFF_FFFF, SP_LAT);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, SP_LAT);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, SP_LAT);
    run("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 34);
    run("rd0", 2'b01, 32'd9, 32'd3, 5'd0, 32'd3, 34);

    issue(2'b01, 32'd100, 32'd7, 5'd20);
    wait_valid(lat);
    check("bp latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp valid", {31'd0, bus.o_valid}, 32'd1);
      check("bp ready", {31'd0, bus.o_ready}, 32'd0);
      check("bp wdata", bus.o_rd_wdata, 32'd14);
      check("bp waddr", {27'd0, bus.o_rd_waddr}, 32'd20);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_ready = 1'b0;
    check("bp release ready", {31'd0, bus.o_ready}, 32'd1);

    issue(2'b01, 32'd100, 32'd7, 5'd21);
    repeat (11) @(posedge clk);
    #1 bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    check("flush ready", {31'd0, bus.o_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= bus.o_valid;
    end
    check("flush no valid", {31'd0, seen}, 32'd0);
    run("post_flush", 2'b01, 32'd9, 32'd3, 5'd22, 32'd3, 34);

    issue(2'b01, 32'd100, 32'd7, 5'd23);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst valid", {31'd0, bus.o_valid}, 32'd0);
    check("mid rst wdata", bus.o_rd_wdata, 32'd0);
    check("mid rst waddr", {27'd0, bus.o_rd_waddr}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst ready", {31'd0, bus.o_ready}, 32'd1);
    check("mid rst valid2", {31'd0, bus.o_valid}, 32'd0);
    run("post_rst", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd24, 32'hFFFF_FFF2, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
